// File: rtl/qual_ack_gen.sv
// qual_ack_gen: answers every enabled c&&d cycle with a=1,b=0 on the next cycle and
//   escalates persistent c/d disagreement to a held fault shown on b.
// Latency: one cycle from the inputs sampled at a posedge to the registered outputs.
// Backpressure: none. Inputs are sampled every cycle, and clr releases a held fault.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   en         qualifier enable (masks c and d when low)
//   c, d       qualifier pair
//   clr        one-cycle pulse clearing a held FAULT
//   a, b       registered acknowledge / busy-fault outputs
//   ack_cnt    saturating count of acknowledges since reset
//   fault_seen sticky flag set on any FAULT entry
module qual_ack_gen #(
  parameter int MIS_LIMIT = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             c,
  input  logic             d,
  input  logic             clr,
  output logic             a,
  output logic             b,
  output logic [CNT_W-1:0] ack_cnt,
  output logic             fault_seen
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  // Terminal value of the mismatch run. The next mismatch at this value trips FAULT.
  localparam logic [7:0] LP_MIS_MAX = 8'(MIS_LIMIT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_mis_run;
  logic [7:0]       w_mis_run_nxt;
  logic [CNT_W-1:0] r_ack_cnt;
  logic             r_fault_seen;

  logic w_qual;
  logic w_mis;
  logic w_fault_trig;

  assign w_qual       = en & c & d;
  assign w_mis        = en & (c ^ d);
  assign w_fault_trig = w_mis && (r_mis_run == LP_MIS_MAX);

  // A qualified cycle wins over everything, including a held fault and a clr.
  // A fresh trigger wins over clr.
  always_comb begin
    w_next = S_IDLE;
    if (w_qual) begin
      w_next = S_ACK;
    end else if (w_fault_trig) begin
      w_next = S_FAULT;
    end else if ((r_state == S_FAULT) && !clr) begin
      w_next = S_FAULT;
    end
  end

  // The run restarts whenever the qualifiers agree or are masked, and on FAULT entry,
  // so that a held fault does not depend on continued mismatch.
  always_comb begin
    w_mis_run_nxt = r_mis_run;
    if (!w_mis || w_fault_trig) begin
      w_mis_run_nxt = 8'd0;
    end else if (r_mis_run != LP_MIS_MAX) begin
      w_mis_run_nxt = r_mis_run + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_mis_run    <= 8'd0;
      r_ack_cnt    <= '0;
      r_fault_seen <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_mis_run <= w_mis_run_nxt;
      if (w_qual && (r_ack_cnt != {CNT_W{1'b1}})) begin
        r_ack_cnt <= r_ack_cnt + 1'b1;
      end
      if (w_fault_trig) begin
        r_fault_seen <= 1'b1;
      end
    end
  end

  // The outputs are decoded only from registered state, so no input reaches them combinationally.
  assign a          = (r_state == S_ACK);
  assign b          = (r_state == S_FAULT);
  assign ack_cnt    = r_ack_cnt;
  assign fault_seen = r_fault_seen;

endmodule

// File: tb/tb_qual_ack_gen.sv
// Directed bench for qual_ack_gen (MIS_LIMIT=3, CNT_W=2): stimulus steps push expected
// outputs into a scoreboard queue, which is popped and compared one cycle later.
module tb_qual_ack_gen;

  localparam int CNT_W = 2;

  typedef struct {
    logic             a;
    logic             b;
    logic [CNT_W-1:0] cnt;
    logic             fs;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             en;
  logic             c;
  logic             d;
  logic             clr;
  logic             a;
  logic             b;
  logic [CNT_W-1:0] ack_cnt;
  logic             fault_seen;

  exp_t             sb_q[$];
  int               n_cmp;
  int               n_fail;
  logic [CNT_W-1:0] m_cnt;

  qual_ack_gen #(.MIS_LIMIT(3), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .c          (c),
    .d          (d),
    .clr        (clr),
    .a          (a),
    .b          (b),
    .ack_cnt    (ack_cnt),
    .fault_seen (fault_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Drive one cycle of inputs, push the expectation for the following cycle, then check it.
  // The expected count comes from a saturating model of the acknowledge count.
  task automatic step(input string tag, input logic i_rst, input logic i_en,
                      input logic i_c, input logic i_d, input logic i_clr,
                      input logic e_a, input logic e_b, input logic e_fs);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst = i_rst; en = i_en; c = i_c; d = i_d; clr = i_clr;
    if (!i_rst) m_cnt = '0;
    else if (i_en && i_c && i_d && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + 1'b1;
    e.a = e_a; e.b = e_b; e.cnt = m_cnt; e.fs = e_fs;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    n_cmp++;
    assert (a === g.a) else begin
      n_fail++;
      $error("FAIL %s.a observed=%b expected=%b", tag, a, g.a);
    end
    n_cmp++;
    assert (b === g.b) else begin
      n_fail++;
      $error("FAIL %s.b observed=%b expected=%b", tag, b, g.b);
    end
    n_cmp++;
    assert (ack_cnt === g.cnt) else begin
      n_fail++;
      $error("FAIL %s.ack_cnt observed=%0d expected=%0d", tag, ack_cnt, g.cnt);
    end
    n_cmp++;
    assert (fault_seen === g.fs) else begin
      n_fail++;
      $error("FAIL %s.fault_seen observed=%b expected=%b", tag, fault_seen, g.fs);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; m_cnt = '0;
    rst = 1'b0; en = 1'b0; c = 1'b0; d = 1'b0; clr = 1'b0;

    // Reset state. The reset also masks a simultaneous qualified cycle.
    step("reset",      0, 1, 1, 1, 0, 0, 0, 0);
    // Basic pass: one qualified cycle gives a single one-cycle acknowledge.
    step("pass_ack",   1, 1, 1, 1, 0, 1, 0, 0);
    step("pass_idle",  1, 1, 0, 0, 0, 0, 0, 0);
    // Reset masking mid-run, then the first qualified cycle after release.
    step("rst_mask",   0, 1, 1, 1, 0, 0, 0, 0);
    step("rel_ack",    1, 1, 1, 1, 0, 1, 0, 0);
    step("rel_idle",   1, 1, 0, 0, 0, 0, 0, 0);
    // Fault entry after three mismatch cycles.
    step("mis1",       1, 1, 0, 1, 0, 0, 0, 0);
    step("mis2",       1, 1, 0, 1, 0, 0, 0, 0);
    step("mis3_fault", 1, 1, 0, 1, 0, 0, 1, 1);
    // The fault holds without continued mismatch.
    for (int i = 0; i < 5; i++) step("fault_hold", 1, 1, 0, 0, 0, 0, 1, 1);
    step("clr_exit",   1, 1, 0, 0, 1, 0, 0, 1);
    // Two mismatches followed by agreement never fault, and the run restarts.
    step("short1",     1, 1, 1, 0, 0, 0, 0, 1);
    step("short2",     1, 1, 1, 0, 0, 0, 0, 1);
    step("short_brk",  1, 1, 0, 0, 0, 0, 0, 1);
    step("short3",     1, 1, 1, 0, 0, 0, 0, 1);
    step("short4",     1, 1, 1, 0, 0, 0, 0, 1);
    step("short_brk2", 1, 1, 0, 0, 0, 0, 0, 1);
    // A qualified cycle leaves FAULT without clr.
    step("f2_mis1",    1, 1, 1, 0, 0, 0, 0, 1);
    step("f2_mis2",    1, 1, 1, 0, 0, 0, 0, 1);
    step("f2_fault",   1, 1, 1, 0, 0, 0, 1, 1);
    step("f2_qual",    1, 1, 1, 1, 0, 1, 0, 1);
    step("f2_idle",    1, 1, 0, 0, 0, 0, 0, 1);
    // clr is ignored in IDLE, loses to a fresh trigger, and loses to qual.
    step("clr_idle",   1, 1, 0, 0, 1, 0, 0, 1);
    step("ct_mis1",    1, 1, 0, 1, 0, 0, 0, 1);
    step("ct_mis2",    1, 1, 0, 1, 0, 0, 0, 1);
    step("clr_trig",   1, 1, 0, 1, 1, 0, 1, 1);
    step("clr_qual",   1, 1, 1, 1, 1, 1, 0, 1);
    // A reset clears the sticky flag and the count.
    step("rst_clear",  0, 0, 0, 0, 0, 0, 0, 0);
    // Back-to-back burst. The count saturates at 3 while a stays high.
    for (int i = 0; i < 6; i++) step("burst", 1, 1, 1, 1, 0, 1, 0, 0);
    step("burst_rst",  0, 1, 1, 1, 0, 0, 0, 0);
    // Enable mask.
    step("pre_mask",   1, 1, 1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++)  step("en0_qual", 1, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("en0_mis",  1, 0, 1, 0, 0, 0, 0, 0);
    // en==0 breaks a mismatch run.
    step("er_mis1",    1, 1, 1, 0, 0, 0, 0, 0);
    step("er_mis2",    1, 1, 1, 0, 0, 0, 0, 0);
    step("er_en0",     1, 0, 1, 0, 0, 0, 0, 0);
    step("er_mis3",    1, 1, 1, 0, 0, 0, 0, 0);
    step("er_mis4",    1, 1, 1, 0, 0, 0, 0, 0);
    step("er_fault",   1, 1, 1, 0, 0, 0, 1, 1);
    // With en low, FAULT holds until clr.
    step("en0_hold",   1, 0, 0, 0, 0, 0, 1, 1);
    step("en0_clr",    1, 0, 1, 1, 1, 0, 0, 1);

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain observed=%0d left expected=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
